// File: rtl/register_file_pkg.sv
// Shared core constants and typedefs (cpu_pkg) used by the register file, ROB, fetch and buffer.
package cpu_pkg;
  localparam int WIDTH = 16;
  localparam int NREGS = 16;
  localparam int LANES = 4;
  localparam int TAG_W = 4;
  localparam int IDX_W = $clog2(NREGS);

  typedef logic [IDX_W-1:0] reg_idx_t;
  typedef logic [TAG_W-1:0] rob_tag_t;
  typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/register_file_if.sv
// Commit, allocate, flush and read-port bundle between ROB/dispatch/buffer and the register file.
interface register_file_if;
  import cpu_pkg::*;

  logic [LANES-1:0] register_write_enable;
  reg_idx_t         register_targets    [LANES];
  word_t            register_write_data [LANES];
  rob_tag_t         register_writers    [LANES];

  logic [LANES-1:0] alloc_valid;
  reg_idx_t         alloc_rt    [LANES];
  rob_tag_t         alloc_owner [LANES];

  logic             flush;

  reg_idx_t         ra_out   [LANES];
  reg_idx_t         rb_out   [LANES];
  word_t            ra_value [LANES];
  word_t            rb_value [LANES];
  logic [LANES-1:0] ra_busy;
  logic [LANES-1:0] rb_busy;
  rob_tag_t         ra_owner [LANES];
  rob_tag_t         rb_owner [LANES];

  modport slave (
    input  register_write_enable, register_targets, register_write_data, register_writers,
    input  alloc_valid, alloc_rt, alloc_owner, flush, ra_out, rb_out,
    output ra_value, rb_value, ra_busy, rb_busy, ra_owner, rb_owner
  );

  modport master (
    output register_write_enable, register_targets, register_write_data, register_writers,
    output alloc_valid, alloc_rt, alloc_owner, flush, ra_out, rb_out,
    input  ra_value, rb_value, ra_busy, rb_busy, ra_owner, rb_owner
  );
endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port: selects value/busy/owner for an index.
// With REGFILE_BYPASS_EN defined, a matching same-cycle commit is forwarded.
module regfile_read_port
  import cpu_pkg::*;
(
  input  word_t            i_values [NREGS],
  input  logic [NREGS-1:0] i_busy,
  input  rob_tag_t         i_owners [NREGS],
  input  reg_idx_t         i_idx,
`ifdef REGFILE_BYPASS_EN
  input  logic [LANES-1:0] i_commit_en,
  input  reg_idx_t         i_commit_tgt    [LANES],
  input  word_t            i_commit_data   [LANES],
  input  rob_tag_t         i_commit_writer [LANES],
`endif
  output word_t            o_value,
  output logic             o_busy,
  output rob_tag_t         o_owner
);

`ifdef REGFILE_BYPASS_EN
  logic [LANES-1:0] w_match;
  word_t            w_fwd_data;

  // A lane forwards only when it retires the exact tag that owns this register.
  always_comb begin
    w_fwd_data = i_values[i_idx];
    for (int l = 0; l < LANES; l++) begin
      w_match[l] = i_commit_en[l] && (i_commit_tgt[l] == i_idx) &&
                   (i_commit_writer[l] == i_owners[i_idx]);
      w_fwd_data = w_match[l] ? i_commit_data[l] : w_fwd_data;
    end
  end

  always_comb begin
    o_owner = i_owners[i_idx];
    if (i_busy[i_idx] && (|w_match)) begin
      o_value = w_fwd_data;
      o_busy  = 1'b0;
    end else begin
      o_value = i_values[i_idx];
      o_busy  = i_busy[i_idx];
    end
  end
`else
  always_comb begin
    o_value = i_values[i_idx];
    o_busy  = i_busy[i_idx];
    o_owner = i_owners[i_idx];
  end
`endif

endmodule

// File: rtl/register_file.sv
// Architectural register file with busy/owner rename tags; 4 commit, 4 alloc, 8 read ports.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle owning commits to the read ports.
module register_file
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  register_file_if.slave bus
);

  word_t            r_value [NREGS];
  logic [NREGS-1:0] r_busy;
  rob_tag_t         r_owner [NREGS];

  word_t            w_value_n [NREGS];
  logic [NREGS-1:0] w_busy_n;
  rob_tag_t         w_owner_n [NREGS];

  logic [NREGS-1:0] w_commit_hit;
  logic [NREGS-1:0] w_commit_clear;
  word_t            w_commit_data [NREGS];
  logic [NREGS-1:0] w_alloc_hit;
  rob_tag_t         w_alloc_tag [NREGS];

  // Per-register lane resolution; ascending scan lets the youngest lane win.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      w_commit_hit[i]   = 1'b0;
      w_commit_clear[i] = 1'b0;
      w_commit_data[i]  = r_value[i];
      w_alloc_hit[i]    = 1'b0;
      w_alloc_tag[i]    = r_owner[i];
      for (int l = 0; l < LANES; l++) begin
        w_commit_hit[i]   = w_commit_hit[i] |
                            (bus.register_write_enable[l] && (bus.register_targets[l] == reg_idx_t'(i)));
        w_commit_clear[i] = (bus.register_write_enable[l] && (bus.register_targets[l] == reg_idx_t'(i))) ?
                            (r_owner[i] == bus.register_writers[l]) : w_commit_clear[i];
        w_commit_data[i]  = (bus.register_write_enable[l] && (bus.register_targets[l] == reg_idx_t'(i))) ?
                            bus.register_write_data[l] : w_commit_data[i];
        w_alloc_hit[i]    = w_alloc_hit[i] |
                            (bus.alloc_valid[l] && (bus.alloc_rt[l] == reg_idx_t'(i)));
        w_alloc_tag[i]    = (bus.alloc_valid[l] && (bus.alloc_rt[l] == reg_idx_t'(i))) ?
                            bus.alloc_owner[l] : w_alloc_tag[i];
      end
    end
  end

  // Flush drops all speculative ownership but retirements still land; alloc beats commit clear.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      w_value_n[i] = w_commit_data[i];
      if (bus.flush) begin
        w_busy_n[i]  = 1'b0;
        w_owner_n[i] = r_owner[i];
      end else if (w_alloc_hit[i]) begin
        w_busy_n[i]  = 1'b1;
        w_owner_n[i] = w_alloc_tag[i];
      end else if (w_commit_hit[i] && w_commit_clear[i]) begin
        w_busy_n[i]  = 1'b0;
        w_owner_n[i] = r_owner[i];
      end else begin
        w_busy_n[i]  = r_busy[i];
        w_owner_n[i] = r_owner[i];
      end
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= {NREGS{1'b0}};
      for (int i = 0; i < NREGS; i++) begin
        r_value[i] <= {WIDTH{1'b0}};
        r_owner[i] <= {TAG_W{1'b0}};
      end
    end else begin
      r_busy <= w_busy_n;
      for (int i = 0; i < NREGS; i++) begin
        r_value[i] <= w_value_n[i];
        r_owner[i] <= w_owner_n[i];
      end
    end
  end

  word_t            w_ra_value [LANES];
  word_t            w_rb_value [LANES];
  logic [LANES-1:0] w_ra_busy;
  logic [LANES-1:0] w_rb_busy;
  rob_tag_t         w_ra_owner [LANES];
  rob_tag_t         w_rb_owner [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    regfile_read_port u_ra (
      .i_values        (r_value),
      .i_busy          (r_busy),
      .i_owners        (r_owner),
      .i_idx           (bus.ra_out[g]),
`ifdef REGFILE_BYPASS_EN
      .i_commit_en     (bus.register_write_enable),
      .i_commit_tgt    (bus.register_targets),
      .i_commit_data   (bus.register_write_data),
      .i_commit_writer (bus.register_writers),
`endif
      .o_value         (w_ra_value[g]),
      .o_busy          (w_ra_busy[g]),
      .o_owner         (w_ra_owner[g])
    );

    regfile_read_port u_rb (
      .i_values        (r_value),
      .i_busy          (r_busy),
      .i_owners        (r_owner),
      .i_idx           (bus.rb_out[g]),
`ifdef REGFILE_BYPASS_EN
      .i_commit_en     (bus.register_write_enable),
      .i_commit_tgt    (bus.register_targets),
      .i_commit_data   (bus.register_write_data),
      .i_commit_writer (bus.register_writers),
`endif
      .o_value         (w_rb_value[g]),
      .o_busy          (w_rb_busy[g]),
      .o_owner         (w_rb_owner[g])
    );
  end

  assign bus.ra_value = w_ra_value;
  assign bus.rb_value = w_rb_value;
  assign bus.ra_busy  = w_ra_busy;
  assign bus.rb_busy  = w_rb_busy;
  assign bus.ra_owner = w_ra_owner;
  assign bus.rb_owner = w_rb_owner;

endmodule
